// File: rtl/coeff_pkg.sv
// Shared definitions for the twiddle coefficient loader: word format,
// default table depth and the loader state encoding.
package coeff_pkg;

    localparam int COEFF_W      = 11;
    localparam int WORD_W       = 2 * COEFF_W;
    localparam int DEFAULT_SIZE = 32;

    // Packed complex coefficient: {re, im}
    typedef logic [WORD_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_e;

endpackage

// File: rtl/coeff_ram_1w1r.sv
// Simple dual-port coefficient RAM: one synchronous write port and one
// synchronous read port. A read that hits the address being written returns
// the contents from before the write. No reset, so it maps onto block or
// distributed RAM.
module coeff_ram_1w1r #(
    parameter int DW    = 22,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write and read in the same process so a colliding read sees the old word
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/coeff_mem_loader.sv
// Run-time loader for a per-stage twiddle coefficient table. Accepts a
// valid/ready stream of coefficient words, writes them to consecutive RAM
// addresses, tracks count and XOR checksum, and exposes a registered read
// port for the butterfly stage.
import coeff_pkg::*;

module coeff_mem_loader #(
    parameter int SIZE = DEFAULT_SIZE,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    output logic              loading,
    output logic              done,
    output logic [AW:0]       wr_count,
    output logic [WORD_W-1:0] checksum,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

    load_state_e       state_q;
    logic              wrReady_q;
    logic              loading_q;
    logic              done_q;
    logic [AW-1:0]     wrAddr_q;
    logic [CNT_W-1:0]  wrCount_q;
    coeff_t            checksum_q;
    logic              rdValid_q;
    logic              rdSeen_q;
    coeff_t            ramRdata;

    logic              transfer_d;
    logic              ramWe_d;

    // A word moves when the loader is ready; a same-cycle start discards it
    always_comb begin
        transfer_d = wr_valid && wrReady_q;
        ramWe_d    = transfer_d && !start;
    end

    // Loader FSM with registered handshake, status, count and checksum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wrReady_q  <= 1'b0;
            loading_q  <= 1'b0;
            done_q     <= 1'b0;
            wrAddr_q   <= '0;
            wrCount_q  <= '0;
            checksum_q <= '0;
        end else if (start) begin
            state_q    <= LOAD;
            wrReady_q  <= 1'b1;
            loading_q  <= 1'b1;
            done_q     <= 1'b0;
            wrAddr_q   <= '0;
            wrCount_q  <= '0;
            checksum_q <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (transfer_d) begin
                        wrAddr_q   <= wrAddr_q + 1'b1;
                        wrCount_q  <= wrCount_q + 1'b1;
                        checksum_q <= checksum_q ^ wr_data;
                        if (wrCount_q == LAST_CNT) begin
                            state_q   <= DONE;
                            wrReady_q <= 1'b0;
                            loading_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read strobe tracking; rdSeen_q masks the unreset RAM output after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdValid_q <= 1'b0;
            rdSeen_q  <= 1'b0;
        end else begin
            rdValid_q <= rd_en;
            rdSeen_q  <= rdSeen_q | rd_en;
        end
    end

    coeff_ram_1w1r #(
        .DW    (WORD_W),
        .DEPTH (SIZE),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ramWe_d),
        .waddr (wrAddr_q),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ramRdata)
    );

    assign wr_ready = wrReady_q;
    assign loading  = loading_q;
    assign done     = done_q;
    assign wr_count = wrCount_q;
    assign checksum = checksum_q;
    assign rd_valid = rdValid_q;
    assign rd_data  = rdSeen_q ? ramRdata : '0;

endmodule
